// File: rtl/digit_overlay.sv
// digit_overlay: VGA pixel-path overlay placed after the digit classifier.
// Draws a one-pixel ring around the centred capture box and renders the most
// recently committed digit as a scaled 3x5 glyph.
//
// Two-stage pipeline. Pixel data and counts come out exactly 2 cycles after they
// go in. Overlay state (box colour, shown digit, freshness) changes only on the
// frame-start cycle, so it cannot change partway through a frame.
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   H_CNT, V_CNT             input pixel coordinates
//   iVGA_R/G/B               input pixel colour
//   DIGIT_IN, DIGIT_VALID    classifier result and its single-cycle strobe
//   BOX_VALID                classifier box-valid level, sampled at frame start
//   oVGA_R/G/B               overlaid output pixel
//   o_H_CNT, o_V_CNT         coordinates aligned with the output pixel
//   DIGIT_SHOWN              currently committed digit
//   SHOW_VALID               committed digit is fresh and is being drawn
module digit_overlay #(
    parameter int unsigned W                  = 160,
    parameter int unsigned H                  = 120,
    parameter int unsigned PIC_DIM            = 30,
    parameter int unsigned PIC_DIM_MULTIPLIER = 3,
    parameter int unsigned DIGIT_SCALE        = 4,
    parameter int unsigned GX                 = 2,
    parameter int unsigned GY                 = 2,
    parameter int unsigned STALE_FRAMES       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] H_CNT,
    input  logic [12:0] V_CNT,
    input  logic [7:0]  iVGA_R,
    input  logic [7:0]  iVGA_G,
    input  logic [7:0]  iVGA_B,
    input  logic [3:0]  DIGIT_IN,
    input  logic        DIGIT_VALID,
    input  logic        BOX_VALID,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic [12:0] o_H_CNT,
    output logic [12:0] o_V_CNT,
    output logic [3:0]  DIGIT_SHOWN,
    output logic        SHOW_VALID
);

    localparam int unsigned S  = PIC_DIM * PIC_DIM_MULTIPLIER;
    localparam int unsigned X0 = (W - S) / 2;
    localparam int unsigned Y0 = (H - S) / 2;

    // The ring sits just outside the box on every side.
    localparam logic [12:0] RingL = 13'(X0 - 1);
    localparam logic [12:0] RingR = 13'(X0 + S);
    localparam logic [12:0] RingT = 13'(Y0 - 1);
    localparam logic [12:0] RingB = 13'(Y0 + S);

    // Glyph region bounds; right and bottom are exclusive.
    localparam int unsigned ScShift = $clog2(DIGIT_SCALE);
    localparam logic [12:0] GlyphL  = 13'(GX);
    localparam logic [12:0] GlyphR  = 13'(GX + 3 * DIGIT_SCALE);
    localparam logic [12:0] GlyphT  = 13'(GY);
    localparam logic [12:0] GlyphB  = 13'(GY + 5 * DIGIT_SCALE);

    localparam int unsigned         StaleW   = $clog2(STALE_FRAMES + 1);
    localparam logic [StaleW-1:0]   StaleMax = StaleW'(STALE_FRAMES);

    // ------------------------------------------------------------------
    // Overlay state, updated only on the frame-start cycle
    // ------------------------------------------------------------------
    logic              r_box_ok;
    logic              r_pend_valid;
    logic [3:0]        r_pend_digit;
    logic [3:0]        r_digit_shown;
    logic              r_show_valid;
    logic [StaleW-1:0] r_stale_cnt;

    logic              w_frame_start;
    logic              w_commit;
    logic [3:0]        w_commit_digit;
    logic [StaleW-1:0] w_stale_inc;

    assign w_frame_start  = (H_CNT == 13'd0) && (V_CNT == 13'd0);
    // A strobe on the frame-start cycle bypasses the pending register.
    assign w_commit       = w_frame_start && (DIGIT_VALID || r_pend_valid);
    assign w_commit_digit = DIGIT_VALID ? DIGIT_IN : r_pend_digit;
    assign w_stale_inc    = (r_stale_cnt == StaleMax) ? StaleMax
                                                      : r_stale_cnt + StaleW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_box_ok      <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_digit  <= 4'd0;
            r_digit_shown <= 4'd0;
            r_show_valid  <= 1'b0;
            r_stale_cnt   <= StaleMax;
        end else if (w_frame_start) begin
            r_box_ok <= BOX_VALID;
            if (w_commit) begin
                r_digit_shown <= w_commit_digit;
                r_stale_cnt   <= '0;
                r_show_valid  <= 1'b1;
                r_pend_valid  <= 1'b0;
            end else begin
                r_stale_cnt <= w_stale_inc;
                if (w_stale_inc == StaleMax) begin
                    r_show_valid <= 1'b0;
                end
            end
        end else if (DIGIT_VALID) begin
            r_pend_valid <= 1'b1;
            r_pend_digit <= DIGIT_IN;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register pixel, classify position
    // ------------------------------------------------------------------
    logic [12:0] w_dx;
    logic [12:0] w_dy;
    logic [1:0]  w_col;
    logic [2:0]  w_row;
    logic        w_on_row;
    logic        w_on_col;
    logic        w_in_glyph;

    // Outside the glyph region these wrap; the region flag masks them.
    assign w_dx  = H_CNT - GlyphL;
    assign w_dy  = V_CNT - GlyphT;
    assign w_col = 2'(w_dx >> ScShift);
    assign w_row = 3'(w_dy >> ScShift);

    assign w_on_row   = ((V_CNT == RingT) || (V_CNT == RingB)) &&
                        (H_CNT >= RingL) && (H_CNT <= RingR);
    assign w_on_col   = ((H_CNT == RingL) || (H_CNT == RingR)) &&
                        (V_CNT >= RingT) && (V_CNT <= RingB);
    assign w_in_glyph = (H_CNT >= GlyphL) && (H_CNT < GlyphR) &&
                        (V_CNT >= GlyphT) && (V_CNT < GlyphB);

    logic [23:0] r_s1_pix;
    logic [12:0] r_s1_h;
    logic [12:0] r_s1_v;
    logic        r_s1_border;
    logic        r_s1_glyph;
    logic [1:0]  r_s1_col;
    logic [2:0]  r_s1_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_pix    <= 24'd0;
            r_s1_h      <= 13'd0;
            r_s1_v      <= 13'd0;
            r_s1_border <= 1'b0;
            r_s1_glyph  <= 1'b0;
            r_s1_col    <= 2'd0;
            r_s1_row    <= 3'd0;
        end else begin
            r_s1_pix    <= {iVGA_R, iVGA_G, iVGA_B};
            r_s1_h      <= H_CNT;
            r_s1_v      <= V_CNT;
            r_s1_border <= w_on_row || w_on_col;
            r_s1_glyph  <= w_in_glyph;
            r_s1_col    <= w_col;
            r_s1_row    <= w_row;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: font lookup and output mux
    // ------------------------------------------------------------------
    logic [14:0] w_font;
    logic [3:0]  w_idx;
    logic [3:0]  w_bit;
    logic        w_lit;
    logic [23:0] w_pix;

    // Row 0 in the MSBs, leftmost column first; 10..15 are blank.
    always_comb begin
        w_font = 15'h0000;
        case (r_digit_shown)
            4'd0:    w_font = 15'h7B6F;
            4'd1:    w_font = 15'h2C97;
            4'd2:    w_font = 15'h73E7;
            4'd3:    w_font = 15'h73CF;
            4'd4:    w_font = 15'h5BC9;
            4'd5:    w_font = 15'h79CF;
            4'd6:    w_font = 15'h79EF;
            4'd7:    w_font = 15'h7249;
            4'd8:    w_font = 15'h7BEF;
            4'd9:    w_font = 15'h7BCF;
            default: w_font = 15'h0000;
        endcase
    end

    assign w_idx = ({1'b0, r_s1_row} * 4'd3) + {2'b00, r_s1_col};
    assign w_bit = 4'd14 - w_idx;
    assign w_lit = w_font[w_bit];

    // Priority: glyph, then border, then passthrough.
    always_comb begin
        w_pix = r_s1_pix;
        if (r_s1_glyph && w_lit && r_show_valid) begin
            w_pix = 24'hFFFFFF;
        end else if (r_s1_border) begin
            w_pix = r_box_ok ? 24'h00FF00 : 24'hFF0000;
        end
    end

    logic [23:0] r_out_pix;
    logic [12:0] r_out_h;
    logic [12:0] r_out_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_pix <= 24'd0;
            r_out_h   <= 13'd0;
            r_out_v   <= 13'd0;
        end else begin
            r_out_pix <= w_pix;
            r_out_h   <= r_s1_h;
            r_out_v   <= r_s1_v;
        end
    end

    assign oVGA_R      = r_out_pix[23:16];
    assign oVGA_G      = r_out_pix[15:8];
    assign oVGA_B      = r_out_pix[7:0];
    assign o_H_CNT     = r_out_h;
    assign o_V_CNT     = r_out_v;
    assign DIGIT_SHOWN = r_digit_shown;
    assign SHOW_VALID  = r_show_valid;

endmodule

// File: tb/tb_digit_overlay.sv
// Self-checking bench for digit_overlay: directed steps from the test plan,
// then a randomized phase, every cycle compared against a behavioural model.
module tb_digit_overlay;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int PD = 30;
    localparam int PM = 3;
    localparam int SC = 4;
    localparam int GX = 2;
    localparam int GY = 2;
    localparam int SF = 8;
    localparam int S  = PD * PM;
    localparam int X0 = (W - S) / 2;
    localparam int Y0 = (H - S) / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] h_cnt, v_cnt;
    logic [7:0]  ir, ig, ib;
    logic [3:0]  din;
    logic        dv, bv;
    logic [7:0]  o_r, o_g, o_b;
    logic [12:0] o_h, o_v;
    logic [3:0]  shown;
    logic        show;

    digit_overlay dut (
        .clk         (clk),
        .rst         (rst),
        .H_CNT       (h_cnt),
        .V_CNT       (v_cnt),
        .iVGA_R      (ir),
        .iVGA_G      (ig),
        .iVGA_B      (ib),
        .DIGIT_IN    (din),
        .DIGIT_VALID (dv),
        .BOX_VALID   (bv),
        .oVGA_R      (o_r),
        .oVGA_G      (o_g),
        .oVGA_B      (o_b),
        .o_H_CNT     (o_h),
        .o_V_CNT     (o_v),
        .DIGIT_SHOWN (shown),
        .SHOW_VALID  (show)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [14:0] font [10];

    // Model state
    int          m_box_ok = 0, m_pend_v = 0, m_pend_d = 0;
    int          m_shown = 0, m_show = 0, m_stale = SF;
    logic [23:0] m_s1_pix = '0, m_out_pix = '0;
    int          m_s1_h = 0, m_s1_v = 0, m_out_h = 0, m_out_v = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] render(input int x, input int y, input logic [23:0] rgb);
        int  col, row;
        bit  lit, ring;
        lit = 0;
        if (x >= GX && x < GX + 3 * SC && y >= GY && y < GY + 5 * SC && m_shown < 10) begin
            col = (x - GX) / SC;
            row = (y - GY) / SC;
            lit = font[m_shown][14 - (row * 3 + col)];
        end
        ring = ((y == Y0 - 1 || y == Y0 + S) && x >= X0 - 1 && x <= X0 + S) ||
               ((x == X0 - 1 || x == X0 + S) && y >= Y0 - 1 && y <= Y0 + S);
        if (lit && m_show != 0) return 24'hFFFFFF;
        if (ring) return (m_box_ok != 0) ? 24'h00FF00 : 24'hFF0000;
        return rgb;
    endfunction

    // Model of what happens on one rising edge, given the inputs presented.
    task automatic model_edge();
        if (rst) begin
            m_box_ok = 0; m_pend_v = 0; m_pend_d = 0;
            m_shown = 0; m_show = 0; m_stale = SF;
            m_s1_pix = '0; m_s1_h = 0; m_s1_v = 0;
            m_out_pix = '0; m_out_h = 0; m_out_v = 0;
        end else begin
            m_out_pix = m_s1_pix; m_out_h = m_s1_h; m_out_v = m_s1_v;
            if (h_cnt == 0 && v_cnt == 0) begin
                m_box_ok = int'(bv);
                if (dv || m_pend_v != 0) begin
                    m_shown  = dv ? int'(din) : m_pend_d;
                    m_stale  = 0;
                    m_show   = 1;
                    m_pend_v = 0;
                end else begin
                    m_stale = (m_stale + 1 > SF) ? SF : m_stale + 1;
                    if (m_stale == SF) m_show = 0;
                end
            end else if (dv) begin
                m_pend_v = 1;
                m_pend_d = int'(din);
            end
            m_s1_pix = render(int'(h_cnt), int'(v_cnt), {ir, ig, ib});
            m_s1_h   = int'(h_cnt);
            m_s1_v   = int'(v_cnt);
        end
    endtask

    task automatic step(input int x, input int y, input logic [23:0] rgb, input logic d_v,
                        input int d, input logic b, input logic r);
        h_cnt = 13'(x); v_cnt = 13'(y);
        {ir, ig, ib} = rgb;
        dv = d_v; din = 4'(d); bv = b; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pix", {8'h0, o_r, o_g, o_b}, {8'h0, m_out_pix});
        chk("model_hcnt", {19'h0, o_h}, 32'(m_out_h));
        chk("model_vcnt", {19'h0, o_v}, 32'(m_out_v));
        chk("model_shown", {28'h0, shown}, 32'(m_shown));
        chk("model_show", {31'h0, show}, 32'(m_show));
    endtask

    // Present one pixel, then a harmless filler, then check the pixel's output.
    task automatic probe(input string tag, input int x, input int y, input logic [23:0] rgb,
                         input logic [23:0] exp);
        step(x, y, rgb, 1'b0, 0, 1'b0, 1'b0);
        step(150, 110, 24'($urandom), 1'b0, 0, 1'b0, 1'b0);
        chk(tag, {8'h0, o_r, o_g, o_b}, {8'h0, exp});
    endtask

    int          x, y;
    logic [23:0] rgb;

    initial begin
        font[0] = 15'h7B6F; font[1] = 15'h2C97; font[2] = 15'h73E7; font[3] = 15'h73CF;
        font[4] = 15'h5BC9; font[5] = 15'h79CF; font[6] = 15'h79EF; font[7] = 15'h7249;
        font[8] = 15'h7BEF; font[9] = 15'h7BCF;

        // Reset with a random stream
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(1, 159), $urandom_range(0, 119), 24'($urandom), 1'($urandom),
                 $urandom_range(0, 15), 1'($urandom), 1'b1);
            chk("reset_pix", {8'h0, o_r, o_g, o_b}, 32'h0);
            chk("reset_hcnt", {19'h0, o_h}, 32'h0);
            chk("reset_vcnt", {19'h0, o_v}, 32'h0);
            chk("reset_shown", {28'h0, shown}, 32'h0);
            chk("reset_show", {31'h0, show}, 32'h0);
        end
        step(100, 100, 24'hABCDEF, 1'b0, 0, 1'b0, 1'b0);
        chk("release_pix", {8'h0, o_r, o_g, o_b}, 32'h0);

        // Passthrough and latency
        step(0, 50, 24'h123456, 1'b0, 0, 1'b0, 1'b0);
        step(34, 50, 24'h777777, 1'b0, 0, 1'b0, 1'b0);
        chk("pass_pix", {8'h0, o_r, o_g, o_b}, 32'h123456);
        chk("pass_hcnt", {19'h0, o_h}, 32'd0);
        chk("pass_vcnt", {19'h0, o_v}, 32'd50);
        step(150, 110, 24'h0, 1'b0, 0, 1'b0, 1'b0);
        chk("border_red", {8'h0, o_r, o_g, o_b}, 32'hFF0000);

        // Border colour after BOX_VALID at frame start
        step(0, 0, 24'h010101, 1'b0, 0, 1'b1, 1'b0);
        probe("border_tl", 34, 14, 24'h111111, 24'h00FF00);
        probe("border_br", 125, 105, 24'h222222, 24'h00FF00);
        probe("border_bot", 80, 105, 24'h333333, 24'h00FF00);
        probe("box_inner", 35, 15, 24'h444444, 24'h444444);

        // Frame-synchronous commit of digit 1
        step(60, 40, 24'h0, 1'b1, 1, 1'b1, 1'b0);
        probe("no_glyph_yet", 6, 2, 24'h555555, 24'h555555);
        chk("pend_shown", {28'h0, shown}, 32'd0);
        chk("pend_show", {31'h0, show}, 32'd0);
        step(0, 0, 24'h0, 1'b0, 0, 1'b1, 1'b0);
        chk("commit_shown", {28'h0, shown}, 32'd1);
        chk("commit_show", {31'h0, show}, 32'd1);
        probe("glyph_2_2", 2, 2, 24'h666666, 24'h666666);
        probe("glyph_6_2", 6, 2, 24'h666666, 24'hFFFFFF);
        probe("glyph_10_21", 10, 21, 24'h666666, 24'hFFFFFF);

        // Staleness
        step(60, 40, 24'h0, 1'b1, 7, 1'b1, 1'b0);
        step(0, 0, 24'h0, 1'b0, 0, 1'b1, 1'b0);
        chk("stale_commit7", {28'h0, shown}, 32'd7);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 24'h0, 1'b0, 0, 1'b1, 1'b0);
            chk($sformatf("stale_show_%0d", k), {31'h0, show}, (k < 8) ? 32'd1 : 32'd0);
        end
        probe("stale_hidden", 6, 2, 24'h888888, 24'h888888);
        step(60, 40, 24'h0, 1'b1, 5, 1'b1, 1'b0);
        step(0, 0, 24'h0, 1'b0, 0, 1'b1, 1'b0);
        chk("restore_show", {31'h0, show}, 32'd1);
        chk("restore_shown", {28'h0, shown}, 32'd5);

        // Strobe on the frame-start cycle commits at once
        step(0, 0, 24'h0, 1'b1, 3, 1'b1, 1'b0);
        chk("same_cycle_shown", {28'h0, shown}, 32'd3);
        chk("same_cycle_show", {31'h0, show}, 32'd1);

        // Digit 12 is blank but still valid
        step(60, 40, 24'h0, 1'b1, 12, 1'b1, 1'b0);
        step(0, 0, 24'h0, 1'b0, 0, 1'b1, 1'b0);
        chk("d12_shown", {28'h0, shown}, 32'd12);
        chk("d12_show", {31'h0, show}, 32'd1);
        probe("d12_blank_a", 6, 2, 24'h999999, 24'h999999);
        probe("d12_blank_b", 2, 2, 24'h999999, 24'h999999);

        // Mid-frame reset
        step(80, 60, 24'hAAAAAA, 1'b0, 0, 1'b1, 1'b1);
        chk("midrst_pix", {8'h0, o_r, o_g, o_b}, 32'h0);
        chk("midrst_shown", {28'h0, shown}, 32'd0);
        chk("midrst_show", {31'h0, show}, 32'd0);
        step(81, 60, 24'hBBBBBB, 1'b0, 0, 1'b0, 1'b0);
        chk("midrst_rel0", {8'h0, o_r, o_g, o_b}, 32'h0);
        step(82, 60, 24'hCCCCCC, 1'b0, 0, 1'b0, 1'b0);
        chk("midrst_rel1", {8'h0, o_r, o_g, o_b}, 32'hBBBBBB);
        probe("midrst_boxok", 34, 50, 24'h0, 24'hFF0000);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0: begin x = $urandom_range(0, 159); y = $urandom_range(0, 119); end
                1: begin x = $urandom_range(0, 15); y = $urandom_range(0, 23); end
                2: begin
                    x = ($urandom_range(0, 1) != 0) ? $urandom_range(32, 36)
                                                    : $urandom_range(123, 127);
                    y = $urandom_range(12, 107);
                end
                default: begin
                    x = $urandom_range(32, 127);
                    y = ($urandom_range(0, 1) != 0) ? $urandom_range(13, 15)
                                                    : $urandom_range(104, 106);
                end
            endcase
            if ($urandom_range(0, 59) == 0) begin
                x = 0; y = 0;
            end
            rgb = 24'($urandom);
            step(x, y, rgb, ($urandom_range(0, 24) == 0), $urandom_range(0, 15),
                 1'($urandom), ($urandom_range(0, 799) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
